align_reader: RTL

ALIGN_READER -- requirements
Module: align_reader

---
 rtl/nw_pkg.sv | 26 ++
 rtl/align_step_decode.sv | 34 +++
 rtl/align_reader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared types for the alignment traceback reader and grid writer.
// Word layout: {y, x}, x in the low CORD_LENGTH bits.
package nw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        DIAG,
        LEFT,
        UP,
        BAD
    } step_t;

    localparam int WORD_X_LSB = 0;

    function automatic int word_y_lsb(input int cord_length);
        return cord_length;
    endfunction

endpackage

// File: rtl/align_step_decode.sv
// Classifies one traceback step prev -> cur into a column type.
module align_step_decode
    import nw_pkg::*;
#(
    parameter int CORD_LENGTH = 8
) (
    input  logic [CORD_LENGTH-1:0] i_prev_x,
    input  logic [CORD_LENGTH-1:0] i_prev_y,
    input  logic [CORD_LENGTH-1:0] i_cur_x,
    input  logic [CORD_LENGTH-1:0] i_cur_y,
    output step_t                  o_step
);

    localparam logic [CORD_LENGTH:0] ONE  = (CORD_LENGTH+1)'(1);
    localparam logic [CORD_LENGTH:0] ZERO = '0;

    // One extra bit so a backwards step cannot alias to +1.
    logic [CORD_LENGTH:0] w_dx;
    logic [CORD_LENGTH:0] w_dy;

    assign w_dx = {1'b0, i_cur_x} - {1'b0, i_prev_x};
    assign w_dy = {1'b0, i_cur_y} - {1'b0, i_prev_y};

    always_comb begin
        o_step = BAD;
        unique case (1'b1)
            (w_dx == ONE)  && (w_dy == ONE):  o_step = DIAG;
            (w_dx == ONE)  && (w_dy == ZERO): o_step = LEFT;
            (w_dx == ZERO) && (w_dy == ONE):  o_step = UP;
            default:                          o_step = BAD;
        endcase
    end

endmodule

// File: rtl/align_reader.sv
// Walks a stored traceback path backwards through memory and emits
// alignment columns in forward order with a running score.
module align_reader
    import nw_pkg::*;
#(
    parameter int        LENGTH      = 10,
    parameter int        CWIDTH      = 2,
    parameter int        SWIDTH      = 16,
    parameter int        CORD_LENGTH = 8,
    parameter int        ADDR_SIZE   = 9,
    parameter int signed MATCH       = 1,
    parameter int signed MISMATCH    = -1,
    parameter int signed INDEL       = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_SIZE:0]       count,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic [ADDR_SIZE-1:0]     raddr,
    input  logic [2*CORD_LENGTH-1:0] rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_gap1,
    output logic                     out_gap2,
    output logic                     out_last,
    output logic                     done,
    output logic                     err,
    output logic signed [SWIDTH-1:0] score
);

    localparam int                     Y_LSB = word_y_lsb(CORD_LENGTH);
    localparam logic [CORD_LENGTH-1:0] C_MAX = CORD_LENGTH'(LENGTH - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_SIZE-1:0]       r_addr;
    logic [CORD_LENGTH-1:0]     r_px;
    logic [CORD_LENGTH-1:0]     r_py;
    logic                       r_first;
    logic [CWIDTH-1:0]          r_c1;
    logic [CWIDTH-1:0]          r_c2;
    logic                       r_g1;
    logic                       r_g2;
    logic                       r_last;
    logic                       r_done;
    logic                       r_err;
    logic signed [SWIDTH-1:0]   r_score;

    logic [CORD_LENGTH-1:0]     w_cx;
    logic [CORD_LENGTH-1:0]     w_cy;
    step_t                      w_step;
    step_t                      w_kind;
    logic                       w_bad;
    logic [CWIDTH-1:0]          w_ch1;
    logic [CWIDTH-1:0]          w_ch2;
    logic [CWIDTH-1:0]          w_c1;
    logic [CWIDTH-1:0]          w_c2;
    logic                       w_g1;
    logic                       w_g2;
    logic signed [SWIDTH-1:0]   w_delta;

    function automatic logic [CWIDTH-1:0] pick(
        input logic [LENGTH*CWIDTH-1:0] s,
        input logic [CORD_LENGTH-1:0]   idx
    );
        pick = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (idx == CORD_LENGTH'(i)) pick = s[i*CWIDTH +: CWIDTH];
        end
    endfunction

    assign w_cx = rdata[WORD_X_LSB +: CORD_LENGTH];
    assign w_cy = rdata[Y_LSB +: CORD_LENGTH];

    align_step_decode #(
        .CORD_LENGTH(CORD_LENGTH)
    ) u_decode (
        .i_prev_x(r_px),
        .i_prev_y(r_py),
        .i_cur_x (w_cx),
        .i_cur_y (w_cy),
        .o_step  (w_step)
    );

    // The path origin has no predecessor and always opens a diagonal.
    always_comb begin
        w_kind = r_first ? DIAG : w_step;
        w_bad  = (w_cx > C_MAX) || (w_cy > C_MAX) || (w_kind == BAD);
        if (r_first && ((w_cx != '0) || (w_cy != '0))) w_bad = 1'b1;
        if ((r_addr == '0) && ((w_cx != C_MAX) || (w_cy != C_MAX))) w_bad = 1'b1;
    end

    always_comb begin
        w_ch1   = pick(s1, w_cy);
        w_ch2   = pick(s2, w_cx);
        w_c1    = '0;
        w_c2    = '0;
        w_g1    = 1'b0;
        w_g2    = 1'b0;
        w_delta = '0;
        case (w_kind)
            DIAG: begin
                w_c1    = w_ch1;
                w_c2    = w_ch2;
                w_delta = (w_ch1 == w_ch2) ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
            end
            LEFT: begin
                w_g1    = 1'b1;
                w_c2    = w_ch2;
                w_delta = SWIDTH'(INDEL);
            end
            UP: begin
                w_c1    = w_ch1;
                w_g2    = 1'b1;
                w_delta = SWIDTH'(INDEL);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (count == '0) ? DONE : FETCH;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = w_bad ? DONE : EMIT;
            EMIT:    if (out_ready) w_next = (r_addr == '0) ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_first <= 1'b0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_score <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= (count == '0) ? '0 : ADDR_SIZE'(count - 1'b1);
                        r_first <= 1'b1;
                        r_err   <= 1'b0;
                        r_score <= '0;
                    end
                end
                WAIT: begin
                    if (w_bad) begin
                        r_err <= 1'b1;
                    end else begin
                        r_c1    <= w_c1;
                        r_c2    <= w_c2;
                        r_g1    <= w_g1;
                        r_g2    <= w_g2;
                        r_last  <= (r_addr == '0);
                        r_px    <= w_cx;
                        r_py    <= w_cy;
                        r_first <= 1'b0;
                        r_score <= r_score + w_delta;
                    end
                end
                EMIT: begin
                    if (out_ready && (r_addr != '0)) r_addr <= r_addr - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == EMIT);
    assign raddr     = r_addr;
    assign out_c1    = r_c1;
    assign out_c2    = r_c2;
    assign out_gap1  = r_g1;
    assign out_gap2  = r_g2;
    assign out_last  = r_last;
    assign done      = r_done;
    assign err       = r_err;
    assign score     = r_score;

endmodule
